// File: rtl/parallel_serial_pkg.sv
// Shared definitions for the serial link: comma symbol and transmitter state encoding.
// The receiver imports the same package for its comma match.
package parallel_serial_pkg;

  localparam logic [7:0] COMMA_SYM = 8'hBC;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/parallel_serial_if.sv
// Byte handshake plus serial line signals of the transmit serializer.
// The master drives bytes in; the slave is the serializer.
interface parallel_serial_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_serial_out;
  logic       frame_start;
  logic       sync_done;
  logic       comma_collision;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_serial_out,
    input  frame_start,
    input  sync_done,
    input  comma_collision
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_serial_out,
    output frame_start,
    output sync_done,
    output comma_collision
  );
endinterface

// File: rtl/parallel_serial_byte_fifo.sv
// Small synchronous byte FIFO with show-ahead output (head is visible without a read cycle).
// Push while full and pop while empty are ignored.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  // Combinational read: the serializer needs the head value at the same edge it pops.
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/parallel_serial.sv
// Transmit serializer: buffers bytes, sends a comma run at bring-up, then user bytes LSB-first,
// filling idle frame slots with the comma symbol.
module parallel_serial
  import parallel_serial_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         NUM_COMMA  = 6,
  parameter logic [7:0] COMMA      = COMMA_SYM
) (
  input  logic              clk,
  input  logic              reset,
  parallel_serial_if.slave  bus
);

  localparam int CW = $clog2(NUM_COMMA + 1);

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic          serial_q, serial_d;
  logic          frame_start_q, frame_start_d;
  logic          sync_done_q, sync_done_d;
  logic          collision_q, collision_d;

  logic          load;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;

  assign fifo_push = bus.valid_in && !fifo_full;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (bus.data_in),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    load          = (bit_cnt_q == 3'd7);
    state_d       = state_q;
    comma_cnt_d   = comma_cnt_q;
    fifo_pop      = 1'b0;
    collision_d   = 1'b0;
    bit_cnt_d     = bit_cnt_q + 3'd1;
    serial_d      = shreg_q[0];
    frame_start_d = (bit_cnt_q == 3'd0);
    shreg_d       = {1'b0, shreg_q[7:1]};

    // Frame boundary: pick the next symbol. The reset-loaded comma counts as the first.
    if (load) begin
      shreg_d = COMMA;
      if (state_q == SYNC) begin
        comma_cnt_d = comma_cnt_q + CW'(1);
        if (comma_cnt_q == CW'(NUM_COMMA - 1)) begin
          state_d = RUN;
        end
      end else if (!fifo_empty) begin
        shreg_d     = fifo_dout;
        fifo_pop    = 1'b1;
        collision_d = (fifo_dout == COMMA);
      end
    end

    sync_done_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SYNC;
      bit_cnt_q     <= 3'd0;
      shreg_q       <= COMMA;
      comma_cnt_q   <= CW'(1);
      serial_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_done_q   <= 1'b0;
      collision_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      comma_cnt_q   <= comma_cnt_d;
      serial_q      <= serial_d;
      frame_start_q <= frame_start_d;
      sync_done_q   <= sync_done_d;
      collision_q   <= collision_d;
    end
  end

  assign bus.ready_out       = !fifo_full;
  assign bus.data_serial_out = serial_q;
  assign bus.frame_start     = frame_start_q;
  assign bus.sync_done       = sync_done_q;
  assign bus.comma_collision = collision_q;

endmodule

// File: tb/tb_parallel_serial.sv
// Bench for the transmit serializer: a frame-level model predicts the symbol sequence,
// and a model receiver on the serial line recovers frames and checks them in order.
module tb_parallel_serial;

  localparam int         DEPTH  = 4;
  localparam int         NCOMMA = 6;
  localparam logic [7:0] K      = 8'hBC;

  typedef struct {
    logic [7:0] b;
    bit         user;
  } frame_t;

  logic clk;
  logic reset;

  parallel_serial_if bus();

  parallel_serial #(
    .FIFO_DEPTH (DEPTH),
    .NUM_COMMA  (NCOMMA),
    .COMMA      (K)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  bit         started = 0;
  bit         last_acc = 0;
  bit         exp_coll = 0;
  int         acc_n = 0;
  int         del_n = 0;
  logic [7:0] pend[$];
  frame_t     exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", nm, act, expv, cyc, $time);
    end
  endtask

  // Frame-level model: frame k (1-based) is chosen at edge 8*(k-1) after reset release.
  // The first NCOMMA frames are commas; afterwards the oldest byte accepted before that edge
  // is sent, else an idle comma.
  initial begin
    logic [7:0] b;
    bit         ready_before;
    forever begin
      @(posedge clk);
      if (reset) begin
        cyc = 0;
        pend.delete();
        exp_q.delete();
        exp_q.push_back('{K, 1'b0});
        exp_coll = 0;
        last_acc = 0;
        acc_n    = 0;
        del_n    = 0;
        started  = 1;
      end else begin
        cyc++;
        ready_before = (pend.size() < DEPTH);
        exp_coll = 0;
        if (cyc % 8 == 0) begin
          if (cyc / 8 + 1 <= NCOMMA) begin
            exp_q.push_back('{K, 1'b0});
          end else if (pend.size() > 0) begin
            b = pend.pop_front();
            exp_q.push_back('{b, 1'b1});
            exp_coll = (b == K);
          end else begin
            exp_q.push_back('{K, 1'b0});
          end
        end
        last_acc = bus.valid_in && ready_before;
        if (last_acc) begin
          pend.push_back(bus.data_in);
          acc_n++;
        end
      end
    end
  end

  // Monitor / model receiver, sampling on the falling edge.
  initial begin
    logic [7:0] rx;
    frame_t     f;
    int         bi;
    rx = '0;
    forever begin
      @(negedge clk);
      if (started) begin
        if (cyc == 0) begin
          chk("rst_serial", 32'(bus.data_serial_out), 0);
          chk("rst_frame_start", 32'(bus.frame_start), 0);
          chk("rst_sync_done", 32'(bus.sync_done), 0);
          chk("rst_collision", 32'(bus.comma_collision), 0);
          chk("rst_ready", 32'(bus.ready_out), 1);
        end else begin
          bi = (cyc - 1) % 8;
          chk("frame_start", 32'(bus.frame_start), 32'(bi == 0));
          chk("sync_done", 32'(bus.sync_done), 32'(cyc >= 8 * (NCOMMA - 1)));
          chk("comma_collision", 32'(bus.comma_collision), 32'(exp_coll));
          chk("ready_out", 32'(bus.ready_out), 32'(pend.size() < DEPTH));
          rx[bi] = bus.data_serial_out;
          if (bi == 7) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL rx_unexpected: got frame %02h expected none (cycle %0d)", rx, cyc);
            end else begin
              f = exp_q.pop_front();
              chk(f.user ? "rx_user_byte" : "rx_comma", 32'(rx), 32'(f.b));
              if (f.user) begin
                del_n++;
                $display("[TB] rx byte %02h valid=1 (#%0d since reset)", rx, del_n);
              end
            end
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done         = 0;
    bus.valid_in = 1'b1;
    bus.data_in  = b;
    for (int i = 0; i < 64 && !done; i++) begin
      @(posedge clk);
      #1;
      if (last_acc) done = 1;
    end
    bus.valid_in = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: byte %02h not accepted within 64 cycles", b);
    end
  endtask

  initial begin
    int n;
    int users_left;
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Bring-up with no traffic: commas only.
    idle(80);

    // One byte pushed during the comma run.
    do_reset(2);
    idle(3);
    send_byte(8'h5A);
    idle(70);

    // Back-to-back burst in RUN, overfilling the buffer.
    for (int v = 1; v <= 6; v++) send_byte(8'(v));
    idle(70);

    // User byte equal to the comma symbol.
    send_byte(K);
    idle(30);

    // One-cycle reset mid-frame with three bytes queued.
    n = 0;
    while (cyc % 8 != 1 && n < 16) begin
      @(posedge clk);
      #1;
      n++;
    end
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("queued_before_reset", 32'(pend.size()), 3);
    do_reset(1);
    idle(80);

    // Randomized traffic with random gaps, occasionally the comma symbol.
    repeat (40) begin
      idle($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) send_byte(K);
      else send_byte(8'($urandom));
    end
    idle(120);

    users_left = 0;
    foreach (exp_q[i]) if (exp_q[i].user) users_left++;
    chk("drain_pending", 32'(pend.size() + users_left), 0);
    chk("drain_delivered", 32'(del_n), 32'(acc_n));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
